// File: rtl/pll_reset_sequencer.sv
// Purpose: drives PLL reset, qualifies lock, and issues a clean domain reset/ready for PLL-output logic.
// Latency: lock-to-ready = LOCK_STABLE_CYCLES+3 refclk edges; lock-loss-to-reset = 3 edges; relock = 1 edge.
// Backpressure: none; free-running controller, relock_req is a single-cycle pulse honoured only in RUN.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       domain_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal values of the shared cycle counter for each timed state.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]       EVT_MAX      = 8'hFF;

  logic           lock_meta;
  logic           locked_s;
  state_t         state_q;
  state_t         state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic           loss_evt;
  logic           timeout_evt;

  // Two-flop synchronizer bringing the asynchronous lock indicator into refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // State and shared cycle counter registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; lock loss outranks a software relock request in RUN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loss_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = RESET_PLL;
          cnt_d       = '0;
          timeout_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE: begin
        // A flap restarts the full lock timeout rather than resetting the PLL.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d  = RESET_PLL;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end else if (relock_req) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating event counters; only rst clears them.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_count <= 8'd0;
      timeout_count   <= 8'd0;
    end else begin
      if (loss_evt && (lock_loss_count != EVT_MAX)) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
      if (timeout_evt && (timeout_count != EVT_MAX)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end

  // Outputs are a pure decode of the state register, so they are glitch-free.
  assign pll_rst    = (state_q == RESET_PLL);
  assign domain_rst = (state_q != RUN);
  assign ready      = (state_q == RUN);
  assign state      = state_q;

endmodule
